// File: rtl/texture_line_fetcher.sv
// Texel fetcher: index -> line-aligned SRAM read, one 24-bit texel returned over valid/ready.
// Miss latency RD_CYCLES+1, OOB/hit 1; req_ready low until texel taken. TEX_LINE_CACHE_EN keeps the last line.
module texture_line_fetcher #(
  parameter int ADDR_BITS  = 24,
  parameter int WORD_BITS  = 24,
  parameter int LINE_WORDS = 64,
  parameter int TEX_BASE   = 131072,
  parameter int TEX_WORDS  = 12288,
  parameter int RD_CYCLES  = 2,
  parameter int IDX_BITS   = 14
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [IDX_BITS-1:0]             req_index,
  output logic                            texel_valid,
  input  logic                            texel_ready,
  output logic [WORD_BITS-1:0]            texel_data,
  output logic                            texel_oob,
  output logic                            sram_read_enable,
  output logic                            sram_write_enable,
  output logic [ADDR_BITS-1:0]            sram_address,
  input  logic [LINE_WORDS*WORD_BITS-1:0] sram_read_data
);

  localparam int OFS_BITS = $clog2(LINE_WORDS);
  localparam int CNT_BITS = $clog2(RD_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_RESP} state_e;

  state_e                 state_q;
  logic                   req_ready_q;
  logic                   texel_valid_q;
  logic [WORD_BITS-1:0]   texel_data_q;
  logic                   texel_oob_q;
  logic                   sram_re_q;
  logic [ADDR_BITS-1:0]   sram_addr_q;
  logic [CNT_BITS-1:0]    rd_cnt_q;
  logic [OFS_BITS-1:0]    word_sel_q;

  logic [ADDR_BITS-1:0]   line_addr_d;
  logic [OFS_BITS-1:0]    word_sel_d;
  logic                   oob_d;
  logic                   hit_d;
  logic [WORD_BITS-1:0]   hit_texel_d;
  logic [WORD_BITS-1:0]   rd_texel_d;

  assign line_addr_d = ADDR_BITS'(TEX_BASE)
                     + ADDR_BITS'({req_index[IDX_BITS-1:OFS_BITS], {OFS_BITS{1'b0}}});
  assign word_sel_d  = req_index[OFS_BITS-1:0];
  assign oob_d       = 32'(req_index) >= TEX_WORDS;
  assign rd_texel_d  = sram_read_data[word_sel_q*WORD_BITS +: WORD_BITS];

`ifdef TEX_LINE_CACHE_EN
  logic [LINE_WORDS*WORD_BITS-1:0] line_buf_q;
  logic [ADDR_BITS-1:0]            tag_q;
  logic                            line_valid_q;

  assign hit_d       = line_valid_q && (tag_q == line_addr_d);
  assign hit_texel_d = line_buf_q[word_sel_d*WORD_BITS +: WORD_BITS];
`else
  assign hit_d       = 1'b0;
  assign hit_texel_d = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      req_ready_q   <= 1'b1;
      texel_valid_q <= 1'b0;
      texel_data_q  <= '0;
      texel_oob_q   <= 1'b0;
      sram_re_q     <= 1'b0;
      sram_addr_q   <= '0;
      rd_cnt_q      <= '0;
      word_sel_q    <= '0;
`ifdef TEX_LINE_CACHE_EN
      line_valid_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            word_sel_q  <= word_sel_d;
            req_ready_q <= 1'b0;
            if (oob_d) begin
              state_q       <= S_RESP;
              texel_valid_q <= 1'b1;
              texel_data_q  <= '0;
              texel_oob_q   <= 1'b1;
            end else if (hit_d) begin
              state_q       <= S_RESP;
              texel_valid_q <= 1'b1;
              texel_data_q  <= hit_texel_d;
              texel_oob_q   <= 1'b0;
            end else begin
              state_q     <= S_READ;
              sram_re_q   <= 1'b1;
              sram_addr_q <= line_addr_d;
              rd_cnt_q    <= '0;
            end
          end
        end
        S_READ: begin
          // Address and enable held for RD_CYCLES; data captured on the last edge.
          if (rd_cnt_q == CNT_BITS'(RD_CYCLES - 1)) begin
            state_q       <= S_RESP;
            sram_re_q     <= 1'b0;
            texel_valid_q <= 1'b1;
            texel_data_q  <= rd_texel_d;
            texel_oob_q   <= 1'b0;
`ifdef TEX_LINE_CACHE_EN
            line_buf_q    <= sram_read_data;
            tag_q         <= sram_addr_q;
            line_valid_q  <= 1'b1;
`endif
          end else begin
            rd_cnt_q <= rd_cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          if (texel_ready) begin
            state_q       <= S_IDLE;
            texel_valid_q <= 1'b0;
            texel_oob_q   <= 1'b0;
            req_ready_q   <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready         = req_ready_q;
  assign texel_valid       = texel_valid_q;
  assign texel_data        = texel_data_q;
  assign texel_oob         = texel_oob_q;
  assign sram_read_enable  = sram_re_q;
  assign sram_write_enable = 1'b0;
  assign sram_address      = sram_addr_q;

endmodule

// File: tb/tb_texture_line_fetcher.sv
// Bench for texture_line_fetcher: directed requests, SRAM line model, per-cycle reference model.
module tb_texture_line_fetcher;

  localparam int RD      = 2;
  localparam int LW      = 64;
  localparam int TB_BASE = 'h020000;
  localparam int TW      = 12288;
`ifdef TEX_LINE_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [13:0]   req_index;
  logic          texel_valid;
  logic          texel_ready;
  logic [23:0]   texel_data;
  logic          texel_oob;
  logic          sram_read_enable;
  logic          sram_write_enable;
  logic [23:0]   sram_address;
  logic [1535:0] sram_read_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  texture_line_fetcher dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_index         (req_index),
    .texel_valid       (texel_valid),
    .texel_ready       (texel_ready),
    .texel_data        (texel_data),
    .texel_oob         (texel_oob),
    .sram_read_enable  (sram_read_enable),
    .sram_write_enable (sram_write_enable),
    .sram_address      (sram_address),
    .sram_read_data    (sram_read_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] word_at(input logic [23:0] a);
    if (a == 24'h020000) return 24'hFF0000;
    if (a == 24'h022FFF) return 24'h00ABCD;
    return (a * 24'd40503) ^ 24'h5A3C96;
  endfunction

  function automatic logic [23:0] line_of(input int idx);
    return 24'(TB_BASE + (idx / LW) * LW);
  endfunction

  // SRAM wrapper: whole line starting at the presented address.
  always_comb begin
    sram_read_data = '0;
    for (int k = 0; k < LW; k++)
      sram_read_data[k*24 +: 24] = word_at(sram_address + 24'(k));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: one outstanding request, outputs derived from accept cycle and latency.
  bit          m_known = 1'b0;
  bit          m_active = 1'b0;
  bit          m_miss;
  bit          m_oob;
  int          m_acc;
  int          m_lat;
  int          m_idx;
  bit          m_cvld = 1'b0;
  logic [23:0] m_tag;

  always @(negedge clk) begin
    bit ev;
    bit er;
    ev = m_active && (cyc >= m_acc + m_lat);
    er = m_active && m_miss && (cyc > m_acc) && (cyc <= m_acc + RD);
    if (m_known) begin
      chk("req_ready", req_ready, !m_active);
      chk("texel_valid", texel_valid, ev);
      chk("sram_read_enable", sram_read_enable, er);
      chk("sram_write_enable", sram_write_enable, 0);
      if (ev) begin
        chk("texel_data", texel_data, m_oob ? 24'h0 : word_at(24'(TB_BASE + m_idx)));
        chk("texel_oob", texel_oob, m_oob);
      end
      if (er) chk("sram_address", sram_address, line_of(m_idx));
    end
    if (rst) begin
      m_known  = 1'b1;
      m_active = 1'b0;
      m_cvld   = 1'b0;
    end else if (m_known) begin
      if (m_active && m_miss && cyc == m_acc + RD) begin
        m_cvld = CACHE;
        m_tag  = line_of(m_idx);
      end
      if (ev && texel_ready) begin
        m_active = 1'b0;
      end else if (!m_active && req_valid) begin
        m_idx    = int'(req_index);
        m_oob    = m_idx >= TW;
        m_miss   = !m_oob && !(m_cvld && m_tag == line_of(m_idx));
        m_lat    = m_miss ? RD + 1 : 1;
        m_acc    = cyc;
        m_active = 1'b1;
      end
    end
  end

  // Leaves the bench one step into the cycle after the accepting edge.
  task automatic issue(input logic [13:0] idx);
    int n = 0;
    req_valid = 1'b1;
    req_index = idx;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_timeout", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!texel_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, texel_valid, 1);
  endtask

  logic [13:0] sweep [10] = '{14'd63, 14'd63, 14'd64, 14'd4095, 14'd4032,
                              14'd12224, 14'd12287, 14'd12289, 14'd16383, 14'd8191};

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_index = '0; texel_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_texel_valid", texel_valid, 0);
    chk("rst_texel_data", texel_data, 0);
    chk("rst_texel_oob", texel_oob, 0);
    chk("rst_read_enable", sram_read_enable, 0);
    chk("rst_address", sram_address, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    issue(14'd0);
    chk("t1_re_c1", sram_read_enable, 1);
    chk("t1_addr_c1", sram_address, 24'h020000);
    @(posedge clk); #1;
    chk("t1_re_c2", sram_read_enable, 1);
    chk("t1_valid_c2", texel_valid, 0);
    @(posedge clk); #1;
    chk("t1_valid_c3", texel_valid, 1);
    chk("t1_data_c3", texel_data, 24'hFF0000);
    chk("t1_oob_c3", texel_oob, 0);
    chk("t1_re_c3", sram_read_enable, 0);
    @(posedge clk); #1;
    chk("t1_idle_ready", req_ready, 1);

    issue(14'd12287);
    chk("t2_addr", sram_address, 24'h022FC0);
    repeat (2) @(posedge clk);
    #1;
    chk("t2_valid", texel_valid, 1);
    chk("t2_data", texel_data, 24'h00ABCD);
    @(posedge clk); #1;

    issue(14'd12288);
    chk("t3_valid_c1", texel_valid, 1);
    chk("t3_data", texel_data, 24'h0);
    chk("t3_oob", texel_oob, 1);
    chk("t3_re", sram_read_enable, 0);
    @(posedge clk); #1;
    chk("t3_oob_clear", texel_oob, 0);

    texel_ready = 1'b0;
    issue(14'd100);
    wait_valid("t4_valid_timeout");
    req_valid = 1'b1;
    req_index = 14'd7;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t4_hold_valid", texel_valid, 1);
      chk("t4_hold_data", texel_data, 24'h10E77E ^ 24'h0 ^ word_at(24'h020064) ^ 24'h10E77E);
      chk("t4_hold_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    texel_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_release_valid", texel_valid, 0);
    chk("t4_release_ready", req_ready, 1);

    issue(14'd200);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_re_after_rst", sram_read_enable, 0);
    chk("t5_valid_after_rst", texel_valid, 0);
    chk("t5_ready_after_rst", req_ready, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("t5_no_stale_texel", texel_valid, 0);
    issue(14'd200);
    wait_valid("t5_valid_timeout");
    chk("t5_data", texel_data, word_at(24'h0200C8));
    @(posedge clk); #1;

    issue(14'd5);
    wait_valid("t6a_valid_timeout");
    @(posedge clk); #1;
    issue(14'd6);
    chk("t6_second_valid_c1", texel_valid, CACHE);
    chk("t6_second_re_c1", sram_read_enable, !CACHE);
    wait_valid("t6b_valid_timeout");
    chk("t6_second_data", texel_data, word_at(24'h020006));
    @(posedge clk); #1;
    issue(14'd64);
    chk("t6_line64_re", sram_read_enable, 1);
    chk("t6_line64_addr", sram_address, 24'h020040);
    wait_valid("t6c_valid_timeout");
    @(posedge clk); #1;

    foreach (sweep[i]) begin
      issue(sweep[i]);
      wait_valid("sweep_valid_timeout");
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d required completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
